// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX frame parser and its helpers.
package uart_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2,
      CSUM    = 2'd3
   } state_t;

   localparam logic [1:0] ERR_CSUM = 2'b01;
   localparam logic [1:0] ERR_LEN  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter; expired is a combinational decode of the registered count.
// Latency: expires during the TIMEOUT_CYC-th consecutive idle cycle while active.
// Backpressure: none; clears on any pop, when inactive, or on expiry.
module uart_frame_timeout #(
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic clk_main,
   input  logic reset,
   input  logic active,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] idle_cnt;

   assign expired = active && (idle_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_main) begin
      if (reset || !active || clear || expired) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// SOF/len/payload/XOR-checksum frame parser on an RX FIFO; inter-byte timeout under PARSER_TIMEOUT_EN.
// Latency: payload byte appears on pay_data one cycle after its FIFO pop; status pulse one cycle after the checksum pop.
// Backpressure: payload/checksum pops stall while pay_valid && !pay_ready; HUNT/LEN drain the FIFO freely.
module uart_rx_frame_parser
   import uart_pkg::*;
#(
   parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT,
   parameter int unsigned MAX_LEN  = 16
`ifdef PARSER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 100000
`endif
) (
   input  logic       clk_main,
   input  logic       reset,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rd_en,
   output logic [7:0] pay_data,
   output logic       pay_valid,
   input  logic       pay_ready,
   output logic       pay_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] good_cnt,
   output logic [7:0] bad_cnt
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t     state;
   logic [7:0] len_rem;
   logic [7:0] csum;
   logic       pay_free;
   logic       tmo_expired;

   // Output slot is free when empty or being drained this cycle.
   assign pay_free = !pay_valid || pay_ready;

`ifdef PARSER_TIMEOUT_EN
   uart_frame_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk_main (clk_main),
      .reset    (reset),
      .active   (state != HUNT),
      .clear    (fifo_rd_en),
      .expired  (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_comb begin
      fifo_rd_en = 1'b0;
      if (!reset && !fifo_empty && !tmo_expired) begin
         case (state)
            HUNT, LEN:     fifo_rd_en = 1'b1;
            PAYLOAD, CSUM: fifo_rd_en = pay_free;
            default:       fifo_rd_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_main) begin
      if (reset) begin
         state     <= HUNT;
         len_rem   <= '0;
         csum      <= '0;
         pay_data  <= '0;
         pay_valid <= 1'b0;
         pay_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (pay_valid && pay_ready) begin
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
         end

         if (tmo_expired) begin
            // Abandon the frame, including any unaccepted payload byte.
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            bad_cnt   <= sat_inc8(bad_cnt);
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            state     <= HUNT;
         end else if (fifo_rd_en) begin
            case (state)
               HUNT: begin
                  if (fifo_rdata == SOF_BYTE) begin
                     state <= LEN;
                  end
               end
               LEN: begin
                  len_rem <= fifo_rdata;
                  csum    <= fifo_rdata;
                  if (fifo_rdata > MAX_LEN_B) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_LEN;
                     bad_cnt   <= sat_inc8(bad_cnt);
                     state     <= HUNT;
                  end else if (fifo_rdata == 8'd0) begin
                     state <= CSUM;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  pay_data  <= fifo_rdata;
                  pay_valid <= 1'b1;
                  pay_last  <= (len_rem == 8'd1);
                  csum      <= csum ^ fifo_rdata;
                  len_rem   <= len_rem - 8'd1;
                  if (len_rem == 8'd1) begin
                     state <= CSUM;
                  end
               end
               CSUM: begin
                  if (fifo_rdata == csum) begin
                     frame_ok <= 1'b1;
                     good_cnt <= good_cnt + 8'd1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CSUM;
                     bad_cnt   <= sat_inc8(bad_cnt);
                  end
                  state <= HUNT;
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: vector table, hand sequences and a randomized stream against a frame-level model.
module tb_uart_rx_frame_parser;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 50;

   logic       clk_main = 1'b0;
   logic       reset;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_rd_en;
   logic [7:0] pay_data;
   logic       pay_valid;
   logic       pay_ready;
   logic       pay_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic [7:0] good_cnt;
   logic [7:0] bad_cnt;

   always #5 clk_main = ~clk_main;

   uart_rx_frame_parser #(
      .SOF_BYTE(8'hA5),
      .MAX_LEN (MAX_LEN)
`ifdef PARSER_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(TMO)
`endif
   ) dut (
      .clk_main  (clk_main),
      .reset     (reset),
      .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata),
      .fifo_rd_en(fifo_rd_en),
      .pay_data  (pay_data),
      .pay_valid (pay_valid),
      .pay_ready (pay_ready),
      .pay_last  (pay_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .good_cnt  (good_cnt),
      .bad_cnt   (bad_cnt)
   );

   // Events: 0x100|b payload byte, 0x200|b last byte, 0x400 ok, 0x800|code error.
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] pq[$];
   logic [7:0] rs[$];
   int         log_q[$];
   int         log_cyc[$];
   int         exp_q[$];
   int         exp_good, exp_bad;
   logic [1:0] exp_code;
   int         cyc = 0;
   int         avail_pct = 100;
   int         ready_pct = 100;
   bit         use_pat = 1'b0;
   bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int         pat_idx = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;

   typedef struct {
      string in_s;
      string pay_s;
      int    st;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic parse(input string s);
      pq.delete();
      for (int p = 0; p + 1 < s.len(); p += 3) pq.push_back(8'(s.substr(p, p + 1).atohex()));
   endtask

   task automatic drive();
      fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) >= avail_pct);
      fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      if (use_pat) begin
         pay_ready = pat[pat_idx];
         pat_idx   = (pat_idx + 1) % 4;
      end else begin
         pay_ready = ($urandom_range(99) < ready_pct);
      end
   endtask

   task automatic push_str(input string s);
      parse(s);
      foreach (pq[j]) fifo_q.push_back(pq[j]);
      drive();
   endtask

   task automatic monitor();
      chk("rd_en_when_empty", fifo_rd_en && fifo_empty, 0);
      chk("ok_and_err_together", frame_ok && frame_err, 0);
      chk("rd_en_while_stalled", pay_valid && !pay_ready && fifo_rd_en, 0);
      if (prev_stall) chk("stall_hold", {pay_valid, pay_last, pay_data}, {1'b1, prev_last, prev_data});
      if (pay_valid && pay_ready) begin
         log_q.push_back((pay_last ? 32'h200 : 32'h100) | 32'(pay_data));
         log_cyc.push_back(cyc);
      end
      if (frame_ok) begin
         log_q.push_back(32'h400);
         log_cyc.push_back(cyc);
      end
      if (frame_err) begin
         log_q.push_back(32'h800 | 32'(err_code));
         log_cyc.push_back(cyc);
      end
      prev_stall = pay_valid && !pay_ready;
      prev_data  = pay_data;
      prev_last  = pay_last;
   endtask

   task automatic tick(input bit rst_chk = 1'b0);
      logic pop;
      @(negedge clk_main);
      cyc++;
      if (rst_chk)
         chk("reset_state", {pay_data, pay_valid, pay_last, frame_ok, frame_err, err_code, good_cnt, bad_cnt}, 0);
      monitor();
      pop = fifo_rd_en;
      @(posedge clk_main);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      drive();
   endtask

   // Called just after a rising edge; reset is held for exactly one edge.
   task automatic do_reset();
      reset = 1'b1;
      drive();
      @(negedge clk_main);
      chk("rd_en_in_reset", fifo_rd_en, 0);
      @(posedge clk_main);
      #1;
      reset      = 1'b0;
      prev_stall = 1'b0;
      exp_good   = 0;
      exp_bad    = 0;
      exp_code   = 2'b00;
      drive();
      tick(1'b1);
   endtask

   task automatic clear_logs();
      log_q.delete();
      log_cyc.delete();
      exp_q.delete();
   endtask

   task automatic cmp_log(input string tag);
      chk({tag, "_event_count"}, log_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
         chk($sformatf("%s_event%0d", tag, k), log_q[k], exp_q[k]);
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_good_cnt"}, good_cnt, 8'(exp_good));
      chk({tag, "_bad_cnt"}, bad_cnt, (exp_bad > 255) ? 255 : exp_bad);
      chk({tag, "_err_code"}, err_code, exp_code);
   endtask

   // Frame-level reference: walks the byte stream and lists what must come out.
   task automatic model(input logic [7:0] s[$]);
      int         i;
      int         len;
      logic [7:0] x;
      i = 0;
      while (i < s.size()) begin
         if (s[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 1 >= s.size()) return;
         len = s[i + 1];
         if (len > MAX_LEN) begin
            exp_q.push_back(32'h802);
            exp_bad++;
            exp_code = 2'b10;
            i += 2;
            continue;
         end
         x = 8'(len);
         for (int k = 0; k < len; k++) begin
            if (i + 2 + k >= s.size()) return;
            x ^= s[i + 2 + k];
            exp_q.push_back(((k == len - 1) ? 32'h200 : 32'h100) | 32'(s[i + 2 + k]));
         end
         if (i + 2 + len >= s.size()) return;
         if (s[i + 2 + len] == x) begin
            exp_q.push_back(32'h400);
            exp_good++;
         end else begin
            exp_q.push_back(32'h801);
            exp_bad++;
            exp_code = 2'b01;
         end
         i += 3 + len;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached before summary, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"A5 03 11 22 33 03", "11 22 33", 32'h400};
      vecs[1] = '{"A5 02 AA 55 FF", "AA 55", 32'h801};
      vecs[2] = '{"00 7E 7E A5 00 00", "", 32'h400};
      vecs[3] = '{"A5 11", "", 32'h802};
      vecs[4] = '{"A5 01 5A 5B", "5A", 32'h400};
      vecs[5] = '{"A5 02 A5 A5 02", "A5 A5", 32'h400};
      vecs[6] = '{"A5 10 00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F 10",
                  "00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F", 32'h400};

      reset      = 1'b1;
      fifo_empty = 1'b1;
      fifo_rdata = 8'h00;
      pay_ready  = 1'b1;
      do_reset();

      // Table-driven vectors, back-to-back, always ready.
      for (int v = 0; v < 7; v++) begin
         int c0, npay, n_in;
         clear_logs();
         parse(vecs[v].pay_s);
         npay = pq.size();
         foreach (pq[j]) exp_q.push_back(((j == npay - 1) ? 32'h200 : 32'h100) | 32'(pq[j]));
         exp_q.push_back(vecs[v].st);
         if (vecs[v].st == 32'h400) exp_good++;
         else begin
            exp_bad++;
            exp_code = 2'(vecs[v].st);
         end
         push_str(vecs[v].in_s);
         n_in = fifo_q.size();
         c0   = cyc;
         repeat (n_in + 6) tick();
         cmp_log($sformatf("vec%0d", v));
         if (npay > 0 && log_cyc.size() == npay + 1) begin
            chk($sformatf("vec%0d_first_byte_latency", v), log_cyc[0] - c0, 4);
            for (int j = 1; j <= npay; j++)
               chk($sformatf("vec%0d_spacing%0d", v, j), log_cyc[j] - log_cyc[j - 1], 1);
         end
         chk_counters($sformatf("vec%0d", v));
      end

      // Backpressure: ready pattern 1-0-0-1 through a 4-byte frame.
      do_reset();
      clear_logs();
      use_pat = 1'b1;
      pat_idx = 0;
      push_str("A5 04 01 02 03 04 00");
      repeat (30) tick();
      use_pat = 1'b0;
      exp_q   = '{32'h101, 32'h102, 32'h103, 32'h204, 32'h400};
      exp_good = 1;
      cmp_log("backpressure");
      chk_counters("backpressure");

      // Reset in the middle of a stalled frame.
      do_reset();
      clear_logs();
      ready_pct = 0;
      push_str("A5 04 01 02");
      repeat (6) tick();
      chk("midframe_stalled_valid", pay_valid, 1);
      fifo_q.delete();
      ready_pct = 100;
      do_reset();
      clear_logs();
      repeat (10) tick();
      chk("after_reset_no_events", log_q.size(), 0);
      push_str("A5 00 00");
      repeat (8) tick();
      exp_q    = '{32'h400};
      exp_good = 1;
      cmp_log("after_reset_frame");
      chk_counters("after_reset_frame");

      // Mid-frame silence.
      do_reset();
      clear_logs();
      begin
         int c0;
         push_str("A5 04 01");
         c0 = cyc;
         repeat (TMO + 20) tick();
`ifdef PARSER_TIMEOUT_EN
         exp_q    = '{32'h101, 32'h803};
         exp_bad  = 1;
         exp_code = 2'b11;
         cmp_log("timeout");
         if (log_cyc.size() == 2) begin
            chk("timeout_not_early", (log_cyc[1] - c0) >= TMO + 3, 1);
            chk("timeout_not_late", (log_cyc[1] - c0) <= TMO + 5, 1);
         end
         chk_counters("timeout");
         clear_logs();
         push_str("A5 01 5A 5B");
         repeat (10) tick();
         exp_q    = '{32'h25A, 32'h400};
         exp_good = 1;
         cmp_log("after_timeout");
         chk_counters("after_timeout");
`else
         exp_q = '{32'h101};
         cmp_log("idle_wait");
         chk_counters("idle_wait");
         clear_logs();
         push_str("02 03 04 00");
         repeat (10) tick();
         exp_q    = '{32'h102, 32'h103, 32'h204, 32'h400};
         exp_good = 1;
         cmp_log("idle_resume");
         chk_counters("idle_resume");
         chk("idle_wait_c0_sane", c0 > 0, 1);
`endif
      end

      // Randomized streams against the frame-level model.
      for (int r = 0; r < 2; r++) begin
         int guard;
         do_reset();
         clear_logs();
         rs.delete();
         repeat (40) begin
            int         len;
            logic [7:0] x;
            repeat ($urandom_range(2)) rs.push_back(8'($urandom_range(255)));
            rs.push_back(8'hA5);
            if ($urandom_range(9) == 0) begin
               rs.push_back(8'(MAX_LEN + 1 + $urandom_range(20)));
               continue;
            end
            len = $urandom_range(MAX_LEN);
            rs.push_back(8'(len));
            x = 8'(len);
            for (int k = 0; k < len; k++) begin
               logic [7:0] b;
               b = 8'($urandom_range(255));
               x ^= b;
               rs.push_back(b);
            end
            rs.push_back(($urandom_range(3) == 0) ? (x ^ 8'(1 + $urandom_range(254))) : x);
         end
         model(rs);
         foreach (rs[j]) fifo_q.push_back(rs[j]);
         avail_pct = (r == 0) ? 100 : 80;
         ready_pct = (r == 0) ? 100 : 70;
         drive();
         guard = 0;
         while ((fifo_q.size() != 0 || pay_valid) && guard < 20000) begin
            tick();
            guard++;
         end
         repeat (4) tick();
         chk($sformatf("rand%0d_drained", r), guard < 20000, 1);
         cmp_log($sformatf("rand%0d", r));
         chk_counters($sformatf("rand%0d", r));
      end
      avail_pct = 100;
      ready_pct = 100;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the UART receive FIFO read port and consumes received bytes.
- Hunts for a start-of-frame byte, then reads a length byte, the payload and an XOR checksum.
- Streams payload bytes out through a valid/ready interface.
- Reports per-frame pass/fail status and keeps good/bad frame counters.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, largest legal payload length in bytes (1..255).
- TIMEOUT_CYC, 100000, inter-byte timeout in clk_main cycles (used only with the optional feature).

Ports:
- clk_main  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  RX FIFO empty flag.
- fifo_rdata  in  8  RX FIFO head byte; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to RX FIFO (combinational).
- pay_data  out  8  payload byte (registered).
- pay_valid  out  1  pay_data valid.
- pay_ready  in  1  consumer accepts pay_data.
- pay_last  out  1  marks the final payload byte of a frame (qualified by pay_valid).
- frame_ok  out  1  one-cycle pulse: checksum matched.
- frame_err  out  1  one-cycle pulse: frame aborted or bad.
- err_code  out  2  01 bad checksum, 10 length > MAX_LEN, 11 timeout; held until next frame_err.
- good_cnt  out  8  good frames, wraps 255->0.
- bad_cnt  out  8  bad frames, saturates at 255.

Behaviour:
- Reset: one cycle of reset=1 forces state=HUNT and clears all outputs/counters to 0. Reset mid-frame discards the partial frame with no status pulse. fifo_rd_en=0 while reset=1.
- Byte consumed = fifo_rd_en=1 at a clock edge. fifo_rd_en is never asserted when fifo_empty=1.
- HUNT:
  - Pop every available byte.
  - If the byte equals SOF_BYTE -> LEN; otherwise discard it and stay in HUNT.
- LEN:
  - Pop one byte; load it into len_rem and into csum (csum = len byte).
  - If len > MAX_LEN: pulse frame_err, err_code=10, bad_cnt++, go to HUNT.
  - If len = 0 -> CSUM.
  - Otherwise -> PAYLOAD.
- PAYLOAD:
  - fifo_rd_en = !fifo_empty && (!pay_valid || pay_ready).
  - On a pop: pay_data<=byte, pay_valid<=1, csum<=csum^byte, len_rem--.
  - pay_last<=1 when len_rem was 1; after that pop -> CSUM.
  - On pay_ready with no new pop, pay_valid<=0.
  - Latency from FIFO pop to pay_valid: 1 cycle. Full throughput of 1 byte/cycle when pay_ready is held high.
- CSUM:
  - Pops only when !fifo_empty && (!pay_valid || pay_ready). This guarantees the status pulse never precedes acceptance of the last payload byte.
  - Byte == csum: pulse frame_ok, good_cnt++.
  - Otherwise: pulse frame_err, err_code=01, bad_cnt++.
  - -> HUNT in both cases.
- Payload is streamed unbuffered: a bad frame's payload has already been delivered, and the consumer must discard it on frame_err.
- An SOF_BYTE value inside LEN/PAYLOAD/CSUM is ordinary data (no resync).
- frame_ok and frame_err are never high together.
- pay_valid, once high, holds pay_data/pay_last stable until pay_ready.

Optional Feature:
- PARSER_TIMEOUT_EN defined:
  - An idle counter runs in LEN/PAYLOAD/CSUM and clears on every pop or state change.
  - When it reaches TIMEOUT_CYC: pulse frame_err, err_code=11, bad_cnt++, clear pay_valid/pay_last, go to HUNT.
  - Timeout takes priority over a simultaneous pop (that byte is not consumed).
- Undefined: no counter; the parser waits indefinitely mid-frame and err_code 11 never occurs.

Decomposition:
- Shared package uart_pkg:
  - state enum (HUNT, LEN, PAYLOAD, CSUM).
  - err_code constants (ERR_CSUM, ERR_LEN, ERR_TMO).
  - default SOF_BYTE.
- One natural sub-module: uart_frame_timeout (counter + expiry flag), instantiated only under PARSER_TIMEOUT_EN. Everything else stays flat.

Test Plan:
- Good frame: A5 03 11 22 33 then csum=03^11^22^33=03, pay_ready=1 -> pay_data 11,22,33 with pay_last on 33; frame_ok pulse; good_cnt=1.
- Bad checksum: A5 02 AA 55 FF -> payload AA,55 delivered; frame_err, err_code=01, bad_cnt=1.
- Garbage then frame: 00 A5-less noise 7E 7E, then A5 00 00 -> noise discarded; zero-length frame gives frame_ok and no pay_valid.
- Length overflow: MAX_LEN=16, send A5 11 -> frame_err, err_code=10; next A5 01 5A 5B parses ok.
- Backpressure: pay_ready toggling 1-0-0-1 during a 4-byte frame -> no byte lost/duplicated, fifo_rd_en low while stalled, status only after last byte accepted.
- Timeout (PARSER_TIMEOUT_EN, TIMEOUT_CYC=50): A5 04 01 then FIFO empty for 50 cycles -> frame_err, err_code=11, return to HUNT; reset asserted mid-frame -> all outputs 0, no pulse.
